instruction_encoder_loader: RTL and testbench
=============================================

// Module: instruction_encoder_loader
// PURPOSE
//  Turns one-hot mnemonic strobes plus a 4-bit operand into SAP-1 instruction words {opcode, operand}.
//  Writes the words one per transaction into program RAM at sequential addresses.
//  Holds the CPU in clear while a load is in progress.
//  It is the writer side of the instruction format the SAP-1 instruction decoder reads.
//  Opcodes: LDA=4'b0000, ADD=4'b0001, SUB=4'b0010, OUT=4'b1110, HLT=4'b1111.
// PARAMETERS
//  ADDR_W      4   RAM address width and operand width; word width = 4+ADDR_W
//  START_ADDR  0   first RAM address written after start
// PORTS
//  clk         in   1         system clock, rising edge
//  rst_n       in   1         synchronous active-low reset
//  start       in   1         begin load session (accepted in IDLE or DONE only)
//  finish      in   1         end session (accepted in LOAD only)
//  in_valid    in   1         mnemonic/operand valid
//  in_ready    out  1         loader accepts a word this cycle
//  mn_lda      in   1         one-hot mnemonic select bits, valid with in_valid
//  mn_add      in   1
//  mn_sub      in   1
//  mn_out      in   1
//  mn_hlt      in   1
//  operand     in   ADDR_W    address field (forced to 0 for OUT/HLT)
//  mem_we      out  1         RAM write strobe, one cycle per word
//  mem_addr    out  ADDR_W    RAM write address
//  mem_data    out  4+ADDR_W  RAM write data {opcode, operand}
//  cpu_clr_n   out  1         0 holds the CPU cleared during load
//  done        out  1         session complete; level, held in DONE
//  err         out  1         sticky: illegal mnemonic or write overflow
//  word_count  out  ADDR_W+1  words written this session
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, in_ready=0, mem_we=0, mem_addr=START_ADDR, mem_data=0.
//   - cpu_clr_n=1, done=0, err=0, word_count=0.
//  FSM states:
//   - IDLE: start -> LOAD; word_count cleared, err cleared, ptr=START_ADDR.
//   - LOAD: in_ready=1; cpu_clr_n=0.
//   - WRITE: one cycle; mem_we=1; in_ready=0; cpu_clr_n=0.
//   - DONE: done=1; cpu_clr_n=1; start -> LOAD with the same clears as from IDLE.
//  Transfer and write:
//   - A transfer occurs when in_valid & in_ready.
//   - mem_we pulses in the cycle after acceptance, with mem_addr=ptr.
//   - Accepted -> WRITE -> LOAD; sustained rate is one word per 2 cycles.
//   - mem_addr/mem_data are registered and stay stable while mem_we=0.
//   - ptr increments by 1 and word_count by 1 on each write.
//  Mnemonic checks:
//   - Mnemonic bits must be exactly one-hot.
//   - Zero or more than one bit set: word dropped, no write, err=1, stays in LOAD.
//  Session end:
//   - A written HLT word takes WRITE -> DONE; no finish is needed.
//   - finish in LOAD with no transfer the same cycle -> DONE.
//   - finish and a transfer in the same cycle: the word is written first, then DONE.
//  Address full / wrap:
//   - A write to address 2^ADDR_W-1 takes the FSM -> DONE.
//   - ptr never wraps.
//   - A later in_valid is not accepted because in_ready=0.
//  Other events:
//   - start while in LOAD or WRITE is ignored.
//   - rst_n=0 mid-session returns all outputs to reset values next edge.
//   - A write pending in WRITE is discarded by rst_n=0.
// CONFIGURATION
//  AUTO_HALT_EN defined:
//   - On finish-driven end with no HLT written this session, the FSM passes through extra state APPEND.
//   - APPEND writes 8'hF0 (HLT, operand 0) at ptr, then -> DONE.
//   - No append if the last address is already written; err=1 in that case.
//  AUTO_HALT_EN undefined:
//   - finish goes directly to DONE; the APPEND state is not present.
// TESTING
//  T1:
//   - Stimulus: reset; start; LDA 9, ADD 10, OUT, HLT.
//   - Response: writes 0x09@0, 0x1A@1, 0xE0@2, 0xF0@3.
//   - Then done=1, cpu_clr_n=1, word_count=4.
//  T2:
//   - Stimulus: in_valid held high continuously.
//   - Response: in_ready toggles 1/0; one mem_we every 2 cycles; no word lost or duplicated.
//  T3:
//   - Stimulus: mn_add & mn_sub together, operand 3.
//   - Response: no mem_we, err=1, ptr unchanged; next legal SUB 3 writes 0x23 at the same address.
//  T4:
//   - Stimulus: 16 LDA words, then a 17th in_valid.
//   - Response: last write at addr 15; DONE; 17th never accepted; word_count=16.
//  T5:
//   - Stimulus: LDA 1, then finish.
//   - Response with AUTO_HALT_EN: 0xF0 written at addr 1, word_count=2.
//   - Response without AUTO_HALT_EN: no extra write, word_count=1.
//  T6:
//   - Stimulus: rst_n low during WRITE, then start again.
//   - Response: no mem_we that cycle; outputs at reset values; next load starts at START_ADDR.

Source files
------------

// File: rtl/instruction_encoder_loader.sv
// Encodes one-hot SAP-1 mnemonics plus operand into {opcode, operand} words and writes them to program RAM.
// Optional AUTO_HALT_EN macro appends an HLT word on a finish-driven end when none was written.
module instruction_encoder_loader #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mn_lda,
    input  logic              mn_add,
    input  logic              mn_sub,
    input  logic              mn_out,
    input  logic              mn_hlt,
    input  logic [ADDR_W-1:0] operand,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W+3:0] mem_data,
    output logic              cpu_clr_n,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
`ifdef AUTO_HALT_EN
        S_APPEND,
`endif
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] START     = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W+3:0] HLT_WORD  = {4'hF, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              we_r;
    logic              finish_pend;
    logic              legal;
    logic              accept;
    logic              wrote_hlt;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] field;
`ifdef AUTO_HALT_EN
    logic              hlt_seen;
    logic              full;
`endif

    assign legal     = $onehot({mn_lda, mn_add, mn_sub, mn_out, mn_hlt});
    assign accept    = in_valid & in_ready & (state == S_LOAD);
    assign wrote_hlt = (mem_data[ADDR_W+3:ADDR_W] == 4'hF);
    // A write in flight is suppressed the moment reset is asserted.
    assign mem_we    = we_r & rst_n;

    always_comb begin
        opcode = 4'h0;
        if (mn_add)      opcode = 4'h1;
        else if (mn_sub) opcode = 4'h2;
        else if (mn_out) opcode = 4'hE;
        else if (mn_hlt) opcode = 4'hF;
        field = (mn_out | mn_hlt) ? '0 : operand;
    end

    task automatic go_done();
        state     <= S_DONE;
        in_ready  <= 1'b0;
        done      <= 1'b1;
        cpu_clr_n <= 1'b1;
    endtask

    task automatic end_session();
`ifdef AUTO_HALT_EN
        if (!hlt_seen && !full) begin
            state    <= S_APPEND;
            in_ready <= 1'b0;
            we_r     <= 1'b1;
            mem_addr <= ptr;
            mem_data <= HLT_WORD;
        end else begin
            if (!hlt_seen) err <= 1'b1;
            go_done();
        end
`else
        go_done();
`endif
    endtask

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            in_ready    <= 1'b0;
            we_r        <= 1'b0;
            mem_addr    <= START;
            mem_data    <= '0;
            cpu_clr_n   <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            word_count  <= '0;
            ptr         <= START;
            finish_pend <= 1'b0;
`ifdef AUTO_HALT_EN
            hlt_seen    <= 1'b0;
            full        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_LOAD;
                        in_ready    <= 1'b1;
                        cpu_clr_n   <= 1'b0;
                        done        <= 1'b0;
                        err         <= 1'b0;
                        word_count  <= '0;
                        ptr         <= START;
                        finish_pend <= 1'b0;
`ifdef AUTO_HALT_EN
                        hlt_seen    <= 1'b0;
                        full        <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    if (accept && legal) begin
                        state       <= S_WRITE;
                        in_ready    <= 1'b0;
                        we_r        <= 1'b1;
                        mem_addr    <= ptr;
                        mem_data    <= {opcode, field};
                        finish_pend <= finish;
                    end else begin
                        if (accept) err <= 1'b1;
                        if (finish) end_session();
                    end
                end
                S_WRITE: begin
                    we_r       <= 1'b0;
                    word_count <= word_count + (ADDR_W+1)'(1);
                    if (mem_addr != LAST_ADDR) ptr <= ptr + ADDR_W'(1);
`ifdef AUTO_HALT_EN
                    full       <= (mem_addr == LAST_ADDR);
                    hlt_seen   <= hlt_seen | wrote_hlt;
`endif
                    if (wrote_hlt || mem_addr == LAST_ADDR) go_done();
                    else if (finish_pend) end_session();
                    else begin
                        state    <= S_LOAD;
                        in_ready <= 1'b1;
                    end
                end
`ifdef AUTO_HALT_EN
                S_APPEND: begin
                    we_r       <= 1'b0;
                    word_count <= word_count + (ADDR_W+1)'(1);
                    hlt_seen   <= 1'b1;
                    if (ptr != LAST_ADDR) ptr <= ptr + ADDR_W'(1);
                    full       <= (ptr == LAST_ADDR);
                    go_done();
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Directed self-checking bench for instruction_encoder_loader; expected words are hand-computed.
module tb_instruction_encoder_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       finish = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       mn_lda = 1'b0, mn_add = 1'b0, mn_sub = 1'b0, mn_out = 1'b0, mn_hlt = 1'b0;
    logic [3:0] operand = '0;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;
    logic       cpu_clr_n;
    logic       done;
    logic       err;
    logic [4:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [3:0] wa[$];
    logic [7:0] wd[$];

    localparam logic [4:0] LDA = 5'b10000, ADD = 5'b01000, SUB = 5'b00100,
                           OUT = 5'b00010, HLT = 5'b00001;

    instruction_encoder_loader #(.ADDR_W(4), .START_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready),
        .mn_lda(mn_lda), .mn_add(mn_add), .mn_sub(mn_sub), .mn_out(mn_out), .mn_hlt(mn_hlt),
        .operand(operand), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .cpu_clr_n(cpu_clr_n), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mn(input logic [4:0] mn);
        {mn_lda, mn_add, mn_sub, mn_out, mn_hlt} = mn;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_finish();
        finish = 1'b1;
        tick();
        finish = 1'b0;
        tick();
    endtask

    task automatic send(input logic [4:0] mn, input logic [3:0] op);
        int unsigned n;
        n = 0;
        set_mn(mn);
        operand  = op;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        set_mn(5'b0);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_data, cpu_clr_n, done, err, word_count} !==
            {1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset_values: rdy=%b we=%b addr=%h data=%h clr_n=%b done=%b err=%b wc=%0d",
                     in_ready, mem_we, mem_addr, mem_data, cpu_clr_n, done, err, word_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_program();
        logic [3:0] ea[4];
        logic [7:0] ed[4];
        ea = '{4'd0, 4'd1, 4'd2, 4'd3};
        ed = '{8'h09, 8'h1A, 8'hE0, 8'hF0};
        wa.delete(); wd.delete();
        do_start();
        checks++;
        if (cpu_clr_n !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_entry: clr_n=%b rdy=%b required 0/1", cpu_clr_n, in_ready);
        end
        send(LDA, 4'd9);
        send(ADD, 4'd10);
        send(OUT, 4'd5);
        send(HLT, 4'd7);
        checks++;
        if (wa.size() !== 4) begin
            errors++;
            $display("FAIL prog_count: writes=%0d required 4", wa.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
                    errors++;
                    $display("FAIL prog_word%0d: %h@%0d required %h@%0d", i, wd[i], wa[i], ed[i], ea[i]);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || cpu_clr_n !== 1'b1 || word_count !== 5'd4) begin
            errors++;
            $display("FAIL prog_end: done=%b clr_n=%b wc=%0d required 1/1/4", done, cpu_clr_n, word_count);
        end
    endtask

    task automatic test_back_to_back();
        logic r;
        int   k;
        wa.delete(); wd.delete();
        do_start();
        k = 0;
        set_mn(LDA);
        operand  = 4'd0;
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            r = in_ready;
            checks++;
            if (r !== ((c % 2) == 0)) begin
                errors++;
                $display("FAIL b2b_ready_c%0d: in_ready=%b required %b", c, r, (c % 2) == 0);
            end
            tick();
            if (r === 1'b1) begin
                k++;
                operand = 4'(k);
            end
        end
        in_valid = 1'b0;
        set_mn(5'b0);
        checks++;
        if (wa.size() !== 6) begin
            errors++;
            $display("FAIL b2b_count: writes=%0d required 6", wa.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wa[i] !== 4'(i) || wd[i] !== 8'(i)) begin
                    errors++;
                    $display("FAIL b2b_word%0d: %h@%0d required %h@%0d", i, wd[i], wa[i], 8'(i), i);
                end
            end
        end
        do_finish();
        checks++;
`ifdef AUTO_HALT_EN
        if (done !== 1'b1 || word_count !== 5'd7) begin
            errors++;
            $display("FAIL b2b_end: done=%b wc=%0d required 1/7", done, word_count);
        end
`else
        if (done !== 1'b1 || word_count !== 5'd6) begin
            errors++;
            $display("FAIL b2b_end: done=%b wc=%0d required 1/6", done, word_count);
        end
`endif
    endtask

    task automatic test_illegal();
        wa.delete(); wd.delete();
        do_start();
        set_mn(ADD | SUB);
        operand  = 4'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        set_mn(5'b0);
        tick();
        checks++;
        if (wa.size() !== 0 || err !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL illegal_drop: writes=%0d err=%b rdy=%b required 0/1/1", wa.size(), err, in_ready);
        end
        set_mn(5'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (wa.size() !== 0 || err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_zero: writes=%0d err=%b required 0/1", wa.size(), err);
        end
        send(SUB, 4'd3);
        checks++;
        if (wa.size() !== 1 || wa[0] !== 4'd0 || wd[0] !== 8'h23 || word_count !== 5'd1 || err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_next: writes=%0d first=%h@%0d wc=%0d err=%b required 1 23@0 1 1",
                     wa.size(), wd[0], wa[0], word_count, err);
        end
        do_finish();
    endtask

    task automatic test_full();
        wa.delete(); wd.delete();
        do_start();
        for (int i = 0; i < 16; i++) send(LDA, 4'(15 - i));
        checks++;
        if (wa.size() !== 16) begin
            errors++;
            $display("FAIL full_count: writes=%0d required 16", wa.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (wa[i] !== 4'(i) || wd[i] !== 8'(15 - i)) begin
                    errors++;
                    $display("FAIL full_word%0d: %h@%0d required %h@%0d", i, wd[i], wa[i], 8'(15 - i), i);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || word_count !== 5'd16) begin
            errors++;
            $display("FAIL full_end: done=%b wc=%0d required 1/16", done, word_count);
        end
        set_mn(LDA);
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL full_17th_c%0d: in_ready=%b required 0", c, in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
        set_mn(5'b0);
        checks++;
        if (wa.size() !== 16 || word_count !== 5'd16) begin
            errors++;
            $display("FAIL full_no_extra: writes=%0d wc=%0d required 16/16", wa.size(), word_count);
        end
    endtask

    task automatic test_finish();
        wa.delete(); wd.delete();
        do_start();
        send(LDA, 4'd1);
        do_finish();
        tick();
        checks++;
`ifdef AUTO_HALT_EN
        if (wa.size() !== 2 || wa[1] !== 4'd1 || wd[1] !== 8'hF0 || word_count !== 5'd2 || done !== 1'b1) begin
            errors++;
            $display("FAIL finish_append: writes=%0d wc=%0d done=%b required 2 writes F0@1, wc 2, done 1",
                     wa.size(), word_count, done);
        end
`else
        if (wa.size() !== 1 || wd[0] !== 8'h01 || word_count !== 5'd1 || done !== 1'b1) begin
            errors++;
            $display("FAIL finish_plain: writes=%0d wc=%0d done=%b required 1/1/1", wa.size(), word_count, done);
        end
`endif
    endtask

    task automatic test_reset_mid_write();
        wa.delete(); wd.delete();
        do_start();
        send(LDA, 4'd1);
        send(LDA, 4'd2);
        set_mn(LDA);
        operand  = 4'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        set_mn(5'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_write_gate: mem_we=%b required 0", mem_we);
        end
        tick();
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_data, cpu_clr_n, done, err, word_count} !==
            {1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL rst_mid_values: rdy=%b we=%b addr=%h data=%h clr_n=%b done=%b err=%b wc=%0d",
                     in_ready, mem_we, mem_addr, mem_data, cpu_clr_n, done, err, word_count);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (wa.size() !== 2) begin
            errors++;
            $display("FAIL rst_discard: writes=%0d required 2", wa.size());
        end
        do_start();
        send(LDA, 4'd6);
        checks++;
        if (wa.size() !== 3 || wa[2] !== 4'd0 || wd[2] !== 8'h06 || word_count !== 5'd1) begin
            errors++;
            $display("FAIL rst_restart: writes=%0d last=%h@%0d wc=%0d required 3 06@0 1",
                     wa.size(), wd[wa.size()-1], wa[wa.size()-1], word_count);
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_back_to_back();
        test_illegal();
        test_full();
        test_finish();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
